// File: rtl/acc_bias_requant_tx.sv
// acc_bias_requant_tx: buffers one bias-added accumulator vector, requantizes
// each element (rounding shift, optional ReLU, saturation) and streams it out.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_valid/o_ready       input vector handshake
//   i_acc_bias            COLS packed signed AB_BW elements, element 0 in LSBs
//   i_shift, i_relu_en    requant controls, sampled at capture
//   o_valid/i_ready       output element handshake
//   o_data, o_col, o_last requantized element, its index, last-element flag
module acc_bias_requant_tx #(
    parameter int COLS     = 5,
    parameter int AB_BW    = 25,
    parameter int O_BW     = 8,
    parameter int SHIFT_BW = 5,
    localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [AB_BW*COLS-1:0] i_acc_bias,
    input  logic [SHIFT_BW-1:0]   i_shift,
    input  logic                  i_relu_en,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [O_BW-1:0]       o_data,
    output logic [CW-1:0]         o_col,
    output logic                  o_last
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(COLS - 1);

    localparam logic signed [AB_BW:0] OMAX = (AB_BW+1)'(2**(O_BW-1) - 1);
    localparam logic signed [AB_BW:0] OMIN = (AB_BW+1)'(-(2**(O_BW-1)));

    state_t               state_q, state_d;
    logic [AB_BW-1:0]     buf_q [COLS];
    logic [SHIFT_BW-1:0]  shift_q;
    logic                 relu_q;
    logic [O_BW-1:0]      data_q, data_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 valid_q, valid_d;
    logic                 load;
    logic                 last;
    logic                 beat;
    logic [CW-1:0]        col_inc;
    logic [AB_BW-1:0]     nxt_elem;

    // Computed in AB_BW+1 bits so adding the rounding constant cannot overflow.
    function automatic logic [O_BW-1:0] rq(
        input logic [AB_BW-1:0]    x,
        input logic [SHIFT_BW-1:0] sh,
        input logic                relu
    );
        int unsigned           si;
        logic signed [AB_BW:0] xe;
        logic signed [AB_BW:0] rnd;
        logic signed [AB_BW:0] y;
        si  = 32'(sh);
        if (si > AB_BW - 1) si = AB_BW - 1;
        xe  = {x[AB_BW-1], x};
        rnd = '0;
        if (si > 0) rnd = (AB_BW+1)'(1) << (si - 1);
        y   = (xe + rnd) >>> si;
        if (relu && y < 0) y = '0;
        if (y > OMAX) return OMAX[O_BW-1:0];
        if (y < OMIN) return OMIN[O_BW-1:0];
        return y[O_BW-1:0];
    endfunction

    assign last    = (col_q == LAST);
    assign beat    = valid_q & i_ready;
    assign col_inc = col_q + CW'(1);

    always_comb begin
        nxt_elem = '0;
        for (int i = 0; i < COLS; i++) begin
            if (CW'(i) == col_inc) nxt_elem = buf_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        col_d   = col_q;
        load    = 1'b0;
        o_ready = 1'b0;
        unique case (state_q)
            IDLE:    o_ready = 1'b1;
            SEND:    o_ready = last & i_ready;
            default: o_ready = 1'b0;
        endcase
        // In SEND a capture can only coincide with the last beat.
        if (i_valid && o_ready) begin
            load    = 1'b1;
            state_d = SEND;
            valid_d = 1'b1;
            col_d   = '0;
            data_d  = rq(i_acc_bias[AB_BW-1:0], i_shift, i_relu_en);
        end else if (beat) begin
            if (!last) begin
                col_d  = col_inc;
                data_d = rq(nxt_elem, shift_q, relu_q);
            end else begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            for (int i = 0; i < COLS; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            col_q   <= col_d;
            if (load) begin
                shift_q <= i_shift;
                relu_q  <= i_relu_en;
                for (int i = 0; i < COLS; i++) begin
                    buf_q[i] <= i_acc_bias[i*AB_BW +: AB_BW];
                end
            end
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_col   = col_q;
    assign o_last  = last;

endmodule

// File: tb/tb_acc_bias_requant_tx.sv
// tb_acc_bias_requant_tx: directed vectors with hand-computed expectations
// for acc_bias_requant_tx; inputs driven and outputs sampled on falling edges.
module tb_acc_bias_requant_tx;

    localparam int COLS  = 5;
    localparam int AB_BW = 25;
    localparam int O_BW  = 8;
    localparam int SB    = 5;
    localparam int CW    = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  i_valid;
    logic                  o_ready;
    logic [AB_BW*COLS-1:0] i_acc_bias;
    logic [SB-1:0]         i_shift;
    logic                  i_relu_en;
    logic                  o_valid;
    logic                  i_ready;
    logic [O_BW-1:0]       o_data;
    logic [CW-1:0]         o_col;
    logic                  o_last;

    int n_chk;
    int n_err;

    acc_bias_requant_tx #(
        .COLS(COLS), .AB_BW(AB_BW), .O_BW(O_BW), .SHIFT_BW(SB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_acc_bias(i_acc_bias), .i_shift(i_shift),
        .i_relu_en(i_relu_en),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_col(o_col), .o_last(o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [AB_BW*COLS-1:0] pack(input int v[COLS]);
        logic [AB_BW*COLS-1:0] r;
        r = '0;
        for (int i = 0; i < COLS; i++) r[i*AB_BW +: AB_BW] = AB_BW'(v[i]);
        return r;
    endfunction

    task automatic chk_beat(input string tag, input int c, input int e);
        chk({tag, " valid"}, int'(o_valid), 1);
        chk({tag, " data"}, $signed(o_data), e);
        chk({tag, " col"}, int'(o_col), c);
        chk({tag, " last"}, int'(o_last), (c == COLS - 1) ? 1 : 0);
    endtask

    // Drive one vector at a falling edge, then check all beats with i_ready=1.
    task automatic run_frame(input string tag, input int v[COLS],
                             input int sh, input bit rl,
                             input int e[COLS]);
        chk({tag, " ready idle"}, int'(o_ready), 1);
        i_acc_bias = pack(v);
        i_shift    = SB'(sh);
        i_relu_en  = rl;
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            chk_beat(tag, c, e[c]);
            @(negedge clk);
        end
        chk({tag, " idle after"}, int'(o_valid), 0);
    endtask

    int va[COLS] = '{100, 300, -300, -128, 0};
    int ea[COLS] = '{100, 127, -128, -128, 0};
    int vb[COLS] = '{1, -1, 127, -129, 50};
    int eb[COLS] = '{1, -1, 127, -128, 50};

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_acc_bias = '0;
        i_shift    = '0;
        i_relu_en  = 1'b0;
        i_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst valid", int'(o_valid), 0);
        chk("rst data", int'(o_data), 0);
        chk("rst col", int'(o_col), 0);
        chk("rst last", int'(o_last), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("sat", va, 0, 1'b0, ea);
        run_frame("shift4", '{40, -40, 8, -8, 16777215}, 4, 1'b0,
                  '{3, -2, 1, 0, 127});
        run_frame("relu", '{-5, 5, -1, 0, 200}, 0, 1'b1,
                  '{0, 5, 0, 0, 127});
        run_frame("bigshift", '{-16777216, 16777215, 1, -1, 0}, 31, 1'b0,
                  '{-1, 1, 0, 0, 0});

        // Backpressure: stall 3 cycles at col 2 with a competing vector.
        i_acc_bias = pack(va);
        i_shift    = '0;
        i_relu_en  = 1'b0;
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        chk_beat("bp", 0, ea[0]);
        @(negedge clk);
        chk_beat("bp", 1, ea[1]);
        @(negedge clk);
        chk_beat("bp", 2, ea[2]);
        i_ready    = 1'b0;
        i_valid    = 1'b1;
        i_acc_bias = pack(vb);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_beat("bp stall", 2, ea[2]);
            chk("bp ready", int'(o_ready), 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk_beat("bp", 3, ea[3]);
        @(negedge clk);
        chk_beat("bp", 4, ea[4]);
        @(negedge clk);
        chk("bp no capture", int'(o_valid), 0);

        // Back-to-back: second vector taken on the first frame's last beat.
        i_acc_bias = pack(va);
        i_valid    = 1'b1;
        i_ready    = 1'b1;
        @(negedge clk);
        i_acc_bias = pack(vb);
        chk("b2b busy", int'(o_ready), 0);
        for (int c = 0; c < COLS; c++) begin
            chk_beat("b2b A", c, ea[c]);
            if (c < COLS - 1) @(negedge clk);
        end
        chk("b2b ready last", int'(o_ready), 1);
        @(negedge clk);
        i_valid = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            chk_beat("b2b B", c, eb[c]);
            @(negedge clk);
        end
        chk("b2b idle", int'(o_valid), 0);

        // Reset mid-frame at col 3.
        i_acc_bias = pack(va);
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid col", int'(o_col), 3);
        rst_n = 1'b0;
        #1;
        chk("arst valid", int'(o_valid), 0);
        chk("arst data", int'(o_data), 0);
        chk("arst col", int'(o_col), 0);
        chk("arst last", int'(o_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst valid", int'(o_valid), 0);
        run_frame("post rst", vb, 0, 1'b0, eb);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
